pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Sequencing controller for the five-stage pipeline registers (F/D, D/X, X/M, M/W) and the PC. It derives every register's write enable and bubble/flush controls from the instructions in decode and execute, the branch outcome, and the multiply/divide unit's handshake. It owns the mult/div issue FSM and a stall-cycle counter. It sits beside the datapath, and every pipeline register's `we` input comes from this block.

## Interface
- `MD_TIMEOUT`, 64: mult/div watchdog limit in cycles, used only with the macro; must be ≥2.
- `CNT_W`, 32: width of `stall_cycles`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `insn_fd` in 32: instruction at F/D output (decode).
- `insn_dx` in 32: instruction at D/X output (execute).
- `branch_taken` in 1: taken branch/jump resolved in X this cycle.
- `md_ready` in 1: mult/div result valid.
- `we_pc`, `we_fd`, `we_dx`, `we_xm`, `we_mw` out 1 each: write enables.
- `flush_fd` out 1: F/D loads nop (32'h0) instead of fetched insn.
- `bubble_dx` out 1: D/X loads nop.
- `bubble_xm` out 1: X/M loads nop.
- `md_ctrl_mult`, `md_ctrl_div` out 1: one-cycle start pulses.
- `md_result_sel` out 1: X/M data mux takes the mult/div result this cycle.
- `md_busy` out 1: FSM in BUSY.
- `md_timeout` out 1: watchdog pulse (macro only, else tied 0).
- `stall_cycles` out CNT_W: count of cycles with `we_pc`=0.

## Operation
- Field decode: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2]. Nop is 32'h0.
- MD instruction: opcode 00000 with ALU op 00110 (mult) or 00111 (div).
- Load-use hazard: `insn_dx` opcode is 01000 (lw), rd_dx≠0, and `insn_fd` reads rd_dx. The reads are:
  - rs, for every opcode except j(00001), jal(00011), bex(10110).
  - rt, for opcode 00000.
  - rd, for sw(00111), bne(00010), blt(00110), jr(00100).
- FSM states: IDLE, BUSY.
  - IDLE → BUSY when `insn_dx` is an MD instruction. That cycle it pulses `md_ctrl_mult` or `md_ctrl_div`.
  - BUSY → IDLE when `md_ready`=1.
- Outputs, first matching rule wins:
  1. MD stall, i.e. issue cycle, or BUSY with `md_ready`=0: `we_pc`=`we_fd`=`we_dx`=0; `we_xm`=`we_mw`=1; `bubble_xm`=1.
  2. BUSY with `md_ready`=1: all `we`=1; `md_result_sel`=1.
  3. `branch_taken`: all `we`=1; `flush_fd`=`bubble_dx`=1.
  4. Load-use: `we_pc`=`we_fd`=0; `we_dx`=1; `bubble_dx`=1; others 1.
  5. Otherwise: all `we`=1; all bubble/flush/pulse outputs 0.
- `branch_taken` is ignored under rule 1, since X holds the MD instruction.
- `md_ready` is ignored in IDLE.
- Back-to-back MD instructions: release, then the next MD instruction reaches X, then it issues again.
- `stall_cycles` increments on every cycle with `we_pc`=0 and wraps modulo 2^CNT_W.

## Timing
- All outputs are combinational from registered state plus current inputs. There are no registered-output delays.
- Issue to release takes at least 2 cycles. `md_ready` is sampled only from the cycle after the pulse onward.
- One MD instruction with ready latency L produces L stall cycles. `stall_cycles` grows by L.
- Load-use inserts exactly 1 bubble. Taken branch discards exactly 2 instructions.
- Reset (synchronous):
  - Next state is IDLE; the watchdog count and `stall_cycles` become 0.
  - While `reset`=1: pulses, `md_result_sel`, `flush_fd`, `bubble_*`, `md_timeout`=0; all `we`=1.
  - Reset during BUSY abandons the operation: no `md_result_sel`, no pulse.
- Post-reset with nop inputs: all `we`=1, all other single-bit outputs 0, `stall_cycles`=0.

## Configuration
- `PIPE_HAZARD_CTRL_MD_TIMEOUT_EN` defined:
  - BUSY counts cycles. At count MD_TIMEOUT−1 with `md_ready`=0, the block pulses `md_timeout`, applies rule 2 with `md_result_sel`=0, and returns to IDLE.
  - `md_ready` in the same cycle wins: normal completion, no timeout.
- Undefined: no counter logic; `md_timeout` is constant 0; BUSY waits indefinitely.

## Test plan
- Reset, then nop stream → all `we`=1, other outputs 0, `stall_cycles`=0 over 10 cycles.
- `insn_dx`=lw rd=5; `insn_fd`=add rs=5 → one cycle with `we_pc`=`we_fd`=0 and `bubble_dx`=1; `stall_cycles`=1. Same test with rd=0 → no stall.
- `insn_dx`=mult, `md_ready` high 4 cycles after the pulse:
  - `md_ctrl_mult` for 1 cycle;
  - stall exactly 4 cycles with `bubble_xm`=1;
  - release cycle has `md_result_sel`=1;
  - `stall_cycles`=4.
- `branch_taken` with a load-use hazard present → `flush_fd`=`bubble_dx`=1, all `we`=1, no stall.
- `reset` asserted mid-BUSY → next cycle IDLE, `md_busy`=0; a later `md_ready` has no effect.
- Macro on, MD_TIMEOUT=8, `md_ready` never asserted → `md_timeout` pulse 8 cycles after issue, then release with `md_result_sel`=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: register write enables, bubbles/flushes, mult/div issue FSM.
// Optional mult/div watchdog enabled by defining PIPE_HAZARD_CTRL_MD_TIMEOUT_EN.
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      insn_fd,
  input  logic [31:0]      insn_dx,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             we_pc,
  output logic             we_fd,
  output logic             we_dx,
  output logic             we_xm,
  output logic             we_mw,
  output logic             flush_fd,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic             md_result_sel,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  // state | meaning
  // IDLE  | no mult/div in flight
  // BUSY  | mult/div issued, waiting for md_ready
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [4:0] OP_ALU = 5'b00000, OP_J = 5'b00001, OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011, OP_JR = 5'b00100, OP_BLT = 5'b00110;
  localparam logic [4:0] OP_SW = 5'b00111, OP_LW = 5'b01000, OP_BEX = 5'b10110;
  localparam logic [4:0] ALU_MULT = 5'b00110, ALU_DIV = 5'b00111;

  state_t     state;
  logic [4:0] op_fd, rd_fd, rs_fd, rt_fd, op_dx, rd_dx, alu_dx;
  logic       reads_rs, reads_rt, reads_rd, load_use, md_dx, busy, md_issue, wd_fire;
  logic       unused_bits;

  assign op_fd  = insn_fd[31:27];
  assign rd_fd  = insn_fd[26:22];
  assign rs_fd  = insn_fd[21:17];
  assign rt_fd  = insn_fd[16:12];
  assign op_dx  = insn_dx[31:27];
  assign rd_dx  = insn_dx[26:22];
  assign alu_dx = insn_dx[6:2];
  assign unused_bits = ^{insn_fd[11:0], insn_dx[21:7], insn_dx[1:0]};

  assign reads_rs = !(op_fd inside {OP_J, OP_JAL, OP_BEX});
  assign reads_rt = (op_fd == OP_ALU);
  assign reads_rd = op_fd inside {OP_SW, OP_BNE, OP_BLT, OP_JR};
  assign load_use = (op_dx == OP_LW) && (rd_dx != 5'd0) &&
                    ((reads_rs && rs_fd == rd_dx) ||
                     (reads_rt && rt_fd == rd_dx) ||
                     (reads_rd && rd_fd == rd_dx));

  assign md_dx    = (op_dx == OP_ALU) && (alu_dx == ALU_MULT || alu_dx == ALU_DIV);
  assign busy     = (state == BUSY);
  assign md_issue = !reset && !busy && md_dx;
  assign md_busy  = busy;

`ifdef PIPE_HAZARD_CTRL_MD_TIMEOUT_EN
  localparam int TW = $clog2(MD_TIMEOUT);
  localparam logic [TW-1:0] WD_LAST = TW'(MD_TIMEOUT - 1);
  logic [TW-1:0] wd_cnt;
  assign wd_fire = busy && !md_ready && (wd_cnt == WD_LAST);
`else
  localparam int unused_md_timeout = MD_TIMEOUT;
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    we_pc         = 1'b1;
    we_fd         = 1'b1;
    we_dx         = 1'b1;
    we_xm         = 1'b1;
    we_mw         = 1'b1;
    flush_fd      = 1'b0;
    bubble_dx     = 1'b0;
    bubble_xm     = 1'b0;
    md_ctrl_mult  = 1'b0;
    md_ctrl_div   = 1'b0;
    md_result_sel = 1'b0;
    md_timeout    = 1'b0;
    if (!reset) begin
      if (md_issue || (busy && !md_ready && !wd_fire)) begin
        we_pc        = 1'b0;
        we_fd        = 1'b0;
        we_dx        = 1'b0;
        bubble_xm    = 1'b1;
        md_ctrl_mult = md_issue && (alu_dx == ALU_MULT);
        md_ctrl_div  = md_issue && (alu_dx == ALU_DIV);
      end else if (busy) begin
        // watchdog expiry releases the pipeline but does not select the stale result
        md_result_sel = md_ready;
        md_timeout    = wd_fire;
      end else if (branch_taken) begin
        flush_fd  = 1'b1;
        bubble_dx = 1'b1;
      end else if (load_use) begin
        we_pc     = 1'b0;
        we_fd     = 1'b0;
        bubble_dx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      stall_cycles <= '0;
`ifdef PIPE_HAZARD_CTRL_MD_TIMEOUT_EN
      wd_cnt       <= '0;
`endif
    end else begin
      if (!we_pc) stall_cycles <= stall_cycles + CNT_W'(1);
      case (state)
        IDLE: begin
          if (md_dx) state <= BUSY;
`ifdef PIPE_HAZARD_CTRL_MD_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        BUSY: begin
          if (md_ready || wd_fire) state <= IDLE;
`ifdef PIPE_HAZARD_CTRL_MD_TIMEOUT_EN
          else wd_cnt <= wd_cnt + TW'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
